// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code sequencer: pops bytes from the ps2_keyboard FIFO, strips E0/F0
// prefixes and emits make/break/repeat key events plus a distinct-press counter.
module ps2_scan_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned PFX_TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_data_in,
  input  logic             ps2_ready,
  input  logic             ps2_overflow,
  output logic             ps2_nextdata_n,
  input  logic             err_clr,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_down,
  output logic             key_valid,
  output logic             key_repeat,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_err,
  output logic             pfx_err
);

  localparam int unsigned TMO_W = (PFX_TIMEOUT > 1) ? $clog2(PFX_TIMEOUT) : 1;
  localparam logic [7:0]  BYTE_EXT = 8'hE0;
  localparam logic [7:0]  BYTE_BRK = 8'hF0;

  typedef enum logic [1:0] {S_IDLE, S_POP, S_PARSE} state_e;

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic             ext_pend_q, ext_pend_d;
  logic             brk_pend_q, brk_pend_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       code_q, code_d;
  logic             kext_q, kext_d;
  logic             down_q, down_d;
  logic [8:0]       held_q, held_d;
  logic             valid_q, valid_d;
  logic             rep_q, rep_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             pfx_q, pfx_d;
  logic             pfx_set;
  logic             held_match;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_q       <= 8'h00;
      nextdata_n_q <= 1'b1;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      tmo_q        <= '0;
      code_q       <= 8'h00;
      kext_q       <= 1'b0;
      down_q       <= 1'b0;
      held_q       <= 9'h000;
      valid_q      <= 1'b0;
      rep_q        <= 1'b0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      pfx_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      nextdata_n_q <= nextdata_n_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
      tmo_q        <= tmo_d;
      code_q       <= code_d;
      kext_q       <= kext_d;
      down_q       <= down_d;
      held_q       <= held_d;
      valid_q      <= valid_d;
      rep_q        <= rep_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      pfx_q        <= pfx_d;
    end
  end

  // Next-state: IDLE -> POP -> PARSE -> IDLE, one byte per three cycles
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ps2_ready) state_d = S_POP;
      S_POP:   state_d = S_PARSE;
      S_PARSE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign held_match = (held_q == {ext_pend_q, byte_q});

  // Datapath / output next values
  always_comb begin
    byte_d       = byte_q;
    nextdata_n_d = 1'b1;
    ext_pend_d   = ext_pend_q;
    brk_pend_d   = brk_pend_q;
    tmo_d        = tmo_q;
    code_d       = code_q;
    kext_d       = kext_q;
    down_d       = down_q;
    held_d       = held_q;
    valid_d      = 1'b0;
    rep_d        = 1'b0;
    cnt_d        = cnt_q;
    pfx_set      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ps2_ready) begin
          byte_d       = ps2_data_in;
          nextdata_n_d = 1'b0;
        end
      end
      S_PARSE: begin
        tmo_d = '0;
        if (byte_q == BYTE_EXT) begin
          ext_pend_d = 1'b1;
        end else if (byte_q == BYTE_BRK) begin
          brk_pend_d = 1'b1;
        end else begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
          if (brk_pend_q) begin
            code_d  = byte_q;
            kext_d  = ext_pend_q;
            valid_d = 1'b1;
            if (held_match) down_d = 1'b0;
          end else if (down_q && held_match) begin
            rep_d = 1'b1;
          end else begin
            code_d  = byte_q;
            kext_d  = ext_pend_q;
            down_d  = 1'b1;
            held_d  = {ext_pend_q, byte_q};
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase

    // A prefix left dangling too long is dropped and flagged
    if (state_q != S_PARSE) begin
      if (ext_pend_q || brk_pend_q) begin
        if (tmo_q == TMO_W'(PFX_TIMEOUT - 1)) begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
          tmo_d      = '0;
          pfx_set    = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end else begin
        tmo_d = '0;
      end
    end

    ovf_d = (ovf_q & ~err_clr) | ps2_overflow;
    pfx_d = (pfx_q & ~err_clr) | pfx_set;
  end

  assign ps2_nextdata_n = nextdata_n_q;
  assign key_code       = code_q;
  assign key_ext        = kext_q;
  assign key_down       = down_q;
  assign key_valid      = valid_q;
  assign key_repeat     = rep_q;
  assign press_cnt      = cnt_q;
  assign ovf_err        = ovf_q;
  assign pfx_err        = pfx_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Scoreboard bench for ps2_scan_ctrl: a FIFO model feeds directed byte streams,
// expected key events are queued by the stimulus and checked by a monitor.
module tb_ps2_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ps2_data_in;
  logic       ps2_ready;
  logic       ps2_overflow;
  logic       ps2_nextdata_n;
  logic       err_clr;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_down;
  logic       key_valid;
  logic       key_repeat;
  logic [7:0] press_cnt;
  logic       ovf_err;
  logic       pfx_err;

  typedef struct packed {
    logic       rep;
    logic [7:0] code;
    logic       ext;
    logic       down;
    logic [7:0] cnt;
  } ev_t;

  logic [7:0] fifo_q[$];
  ev_t        exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         pop_cnt = 0;

  ps2_scan_ctrl #(.CNT_W(8), .PFX_TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .ps2_data_in    (ps2_data_in),
    .ps2_ready      (ps2_ready),
    .ps2_overflow   (ps2_overflow),
    .ps2_nextdata_n (ps2_nextdata_n),
    .err_clr        (err_clr),
    .key_code       (key_code),
    .key_ext        (key_ext),
    .key_down       (key_down),
    .key_valid      (key_valid),
    .key_repeat     (key_repeat),
    .press_cnt      (press_cnt),
    .ovf_err        (ovf_err),
    .pfx_err        (pfx_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_b(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic exp_ev(input logic rep, input logic [7:0] code, input logic ext,
                        input logic down, input logic [7:0] cnt);
    ev_t e;
    e.rep = rep; e.code = code; e.ext = ext; e.down = down; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // FIFO model: pops on a low strobe, presents the new head after the pop
  task automatic fifo_model();
    logic prev_low = 1'b0;
    forever begin
      @(negedge clk);
      if (!ps2_nextdata_n) begin
        check("pop_strobe_single", 32'(prev_low), 32'd0);
        pop_cnt++;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      end
      prev_low    = !ps2_nextdata_n;
      ps2_ready   = (fifo_q.size() != 0);
      ps2_data_in = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  endtask

  // Monitor: every event pulse is matched against the head of the expected queue
  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (key_valid || key_repeat) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {11'd0, key_valid, key_repeat, key_code, key_ext, key_down, press_cnt}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("event", {11'd0, key_valid, key_repeat, key_code, key_ext, key_down, press_cnt},
                {11'd0, ~e.rep, e.rep, e.code, e.ext, e.down, e.cnt});
        end
      end
    end
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (fifo_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n >= max_cyc), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_nextdata_n"}, 32'(ps2_nextdata_n), 32'd1);
    check({tag, "_key_code"},   32'(key_code),       32'd0);
    check({tag, "_key_ext"},    32'(key_ext),        32'd0);
    check({tag, "_key_down"},   32'(key_down),       32'd0);
    check({tag, "_pulses"},     {30'd0, key_valid, key_repeat}, 32'd0);
    check({tag, "_press_cnt"},  32'(press_cnt),      32'd0);
    check({tag, "_errs"},       {30'd0, ovf_err, pfx_err}, 32'd0);
  endtask

  initial begin
    logic [7:0] c;
    logic [7:0] cnt;
    int n;
    rst = 1'b1; ps2_data_in = 8'h00; ps2_ready = 1'b0;
    ps2_overflow = 1'b0; err_clr = 1'b0;
    fork
      fifo_model();
      monitor();
    join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");

    // Make then break, three pops
    pop_cnt = 0;
    push_b(8'h1C); push_b(8'hF0); push_b(8'h1C);
    exp_ev(0, 8'h1C, 0, 1, 8'd1);
    exp_ev(0, 8'h1C, 0, 0, 8'd1);
    drain(50);
    check("mb_pop_cnt", 32'(pop_cnt), 32'd3);
    check("mb_press_cnt", 32'(press_cnt), 32'd1);

    // Typematic repeats do not count
    push_b(8'h1C); push_b(8'h1C); push_b(8'h1C); push_b(8'hF0); push_b(8'h1C);
    exp_ev(0, 8'h1C, 0, 1, 8'd2);
    exp_ev(1, 8'h1C, 0, 1, 8'd2);
    exp_ev(1, 8'h1C, 0, 1, 8'd2);
    exp_ev(0, 8'h1C, 0, 0, 8'd2);
    drain(60);
    check("typ_press_cnt", 32'(press_cnt), 32'd2);

    // Extended make and extended break
    push_b(8'hE0); push_b(8'h75); push_b(8'hE0); push_b(8'hF0); push_b(8'h75);
    exp_ev(0, 8'h75, 1, 1, 8'd3);
    exp_ev(0, 8'h75, 1, 0, 8'd3);
    drain(60);

    // Stale break, rollover, break of the non-held key, then real break
    push_b(8'hF0); push_b(8'h22);
    push_b(8'h1C); push_b(8'h32);
    push_b(8'hF0); push_b(8'h1C);
    push_b(8'hF0); push_b(8'h32);
    exp_ev(0, 8'h22, 0, 0, 8'd3);
    exp_ev(0, 8'h1C, 0, 1, 8'd4);
    exp_ev(0, 8'h32, 0, 1, 8'd5);
    exp_ev(0, 8'h1C, 0, 1, 8'd5);
    exp_ev(0, 8'h32, 0, 0, 8'd5);
    drain(80);

    // Prefix timeout
    push_b(8'hF0);
    drain(20);
    repeat (8) @(negedge clk);
    check("pfx_before_timeout", 32'(pfx_err), 32'd0);
    repeat (12) @(negedge clk);
    check("pfx_after_timeout", 32'(pfx_err), 32'd1);
    push_b(8'h1C);
    exp_ev(0, 8'h1C, 0, 1, 8'd6);
    drain(20);
    check("pfx_make_down", 32'(key_down), 32'd1);

    // Overflow sticky, set beats clear, then clear
    ps2_overflow = 1'b1;
    @(negedge clk);
    ps2_overflow = 1'b0;
    check("ovf_set", 32'(ovf_err), 32'd1);
    ps2_overflow = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    ps2_overflow = 1'b0;
    check("ovf_set_wins", {30'd0, ovf_err, pfx_err}, 32'd2);
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", {30'd0, ovf_err, pfx_err}, 32'd0);

    // Reset while in S_POP: popped byte lost, next byte accepted
    ps2_overflow = 1'b1;
    @(negedge clk);
    ps2_overflow = 1'b0;
    push_b(8'h5A); push_b(8'h33);
    n = 0;
    while (ps2_nextdata_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_wait_pop", 32'(n >= 20), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("rst_mid");
    exp_ev(0, 8'h33, 0, 1, 8'd1);
    drain(30);
    push_b(8'hF0); push_b(8'h33);
    exp_ev(0, 8'h33, 0, 0, 8'd1);
    drain(30);

    // Counter wrap over 256 distinct makes
    do_reset();
    cnt = 8'd0;
    for (int i = 0; i < 256; i++) begin
      c = (i % 2 == 0) ? 8'h1C : 8'h32;
      cnt = cnt + 8'd1;
      push_b(c); push_b(8'hF0); push_b(c);
      exp_ev(0, c, 0, 1, cnt);
      exp_ev(0, c, 0, 0, cnt);
      if (i == 254) begin
        drain(3000);
        check("wrap_before_last", 32'(press_cnt), 32'hFF);
      end
    end
    drain(3000);
    check("wrap_after_last", 32'(press_cnt), 32'h00);

    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scan_ctrl.md
Name: ps2_scan_ctrl

Overview:
Sequencer that drains the ps2_keyboard receive FIFO through its ready/nextdata_n handshake and turns the raw scan-code byte stream into key events.
- Parses 0xE0 (extended) and 0xF0 (break) prefixes.
- Tracks the currently held key and suppresses typematic repeats in the press counter.
- Drives the code/count values shown on the seven-segment displays.
- Sits between ps2_keyboard and the bcd7seg display logic in top.

Parameters:
CNT_W, 8, width of key-press counter (wraps modulo 2^CNT_W)
PFX_TIMEOUT, 1000000, clk cycles a pending E0/F0 prefix may wait for its code byte before being discarded

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
ps2_data_in  input  8  FIFO head byte from ps2_keyboard (data)
ps2_ready  input  1  FIFO non-empty from ps2_keyboard (ready)
ps2_overflow  input  1  FIFO overflow flag from ps2_keyboard
ps2_nextdata_n  output  1  active-low pop strobe to ps2_keyboard
err_clr  input  1  clears sticky error flags
key_code  output  8  last make/break code byte (prefix stripped)
key_ext  output  1  key_code came with E0 prefix
key_down  output  1  a key is currently held
key_valid  output  1  one-cycle pulse: new make or break event
key_repeat  output  1  one-cycle pulse: typematic repeat of held key
press_cnt  output  CNT_W  count of distinct make events
ovf_err  output  1  sticky: ps2_overflow seen high
pfx_err  output  1  sticky: prefix timed out

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to S_IDLE.
  - ps2_nextdata_n=1; key_code=0x00; key_ext=0; key_down=0; key_valid=0; key_repeat=0; press_cnt=0; ovf_err=0; pfx_err=0.
  - Prefix flags ext_pend and brk_pend cleared; timeout counter cleared.
  - Reset mid-sequence abandons any captured byte. A byte already popped is lost; a byte not yet popped stays in the FIFO.
- FSM, one byte per 3 cycles minimum:
  - S_IDLE: if ps2_ready=1, capture ps2_data_in into byte_r, drive ps2_nextdata_n<=0, go to S_POP. Otherwise stay.
  - S_POP: ps2_nextdata_n<=1, go to S_PARSE. The pop strobe is low for exactly one cycle per byte, never two consecutive cycles.
  - S_PARSE: decode byte_r (rules below), go to S_IDLE. ps2_ready is not sampled here, because the FIFO pointer has just moved.
- Decode in S_PARSE:
  - 0xE0: ext_pend<=1; no event.
  - 0xF0: brk_pend<=1; no event; ext_pend is kept, so the sequence E0 F0 xx is an extended break.
  - Any other byte C with brk_pend=1 (break):
    - key_code<=C, key_ext<=ext_pend, key_valid pulse.
    - If C and ext_pend match the held key, key_down<=0. Otherwise key_down is unchanged; a stale break still pulses key_valid.
  - Any other byte C with brk_pend=0 (make):
    - If key_down=1 and {ext_pend,C} equals the held key: key_repeat pulse only. No key_valid, no count change.
    - Otherwise: key_code<=C, key_ext<=ext_pend, key_down<=1, key_valid pulse, press_cnt<=press_cnt+1 (wraps 2^CNT_W-1 -> 0).
  - After any non-prefix byte, clear ext_pend and brk_pend.
- Event timing: key_valid and key_repeat go high in the cycle after S_PARSE and last one cycle. key_code, key_ext and key_down update on that same edge and then hold.
- Prefix timeout:
  - The counter runs while (ext_pend|brk_pend)=1 and is cleared when both flags are clear or a byte is parsed.
  - When it reaches PFX_TIMEOUT-1: clear both flags, set pfx_err. No event is emitted.
- ovf_err: set on any cycle ps2_overflow=1. err_clr=1 clears ovf_err and pfx_err.
  - If err_clr and a set condition occur in the same cycle, set wins.
  - Errors never stall the FSM.
- Only one held key is tracked. A new make while another key is held replaces the held key (rollover).

Test Plan:
- Make/break: FIFO bytes 1C, F0, 1C. Expect key_valid pulse with key_code=1C, key_down=1, press_cnt=1. Then key_valid pulse with key_code=1C, key_down=0; press_cnt stays 1. ps2_nextdata_n is low exactly 3 single cycles.
- Typematic: 1C, 1C, 1C, F0, 1C. Expect one key_valid make, two key_repeat pulses, press_cnt=1, then a break with key_down=0.
- Extended: E0, 75, E0, F0, 75. Expect make key_code=75, key_ext=1, key_down=1, then break key_ext=1, key_down=0. No events emitted on the E0 or F0 bytes.
- Counter wrap with CNT_W=8: 256 alternating distinct makes (1C, 32, 1C, ...) each followed by its break. Expect press_cnt=0x00 after the 256th make and 0xFF before it.
- Timeout and errors with PFX_TIMEOUT=16: send F0, then idle 20 cycles, then 1C. Expect pfx_err=1 and 1C decoded as a make (key_down=1). Pulse ps2_overflow for 1 cycle: expect ovf_err=1. Assert err_clr: both errors clear next cycle.
- Reset mid-operation: assert rst during S_POP. Expect all outputs at reset values next cycle, ps2_nextdata_n=1, and the FSM accepting the next FIFO byte normally.
